// File: rtl/ct_f_sram_pkg.sv
// -----------------------------------------------------------------------------
// ct_f_sram_pkg
// Shared types and helpers for the generic FPGA single-port SRAM wrapper.
//   sram_init_state_e : sweep FSM states (INIT = zero-fill, IDLE = serve accesses)
//   slice_msb()       : bit index of the MSB of a write slice; this is the only
//                       WEN bit sampled for that slice
// -----------------------------------------------------------------------------
package ct_f_sram_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      IDLE = 1'b1
   } sram_init_state_e;

   function automatic int slice_msb(input int s, input int w);
      return (s + 1) * w - 1;
   endfunction

endpackage

// File: rtl/ct_f_spsram_gen_if.sv
// -----------------------------------------------------------------------------
// ct_f_spsram_gen_if
// Access bus of ct_f_spsram_gen. Signal names keep the legacy macro names.
//   A        word address             CEN  chip enable, active low
//   GWEN     global write, active low WEN  bit write enables, active low
//   D        write data               Q    read data
//   BUSY     zero-init sweep running  ADDR_ERR  out-of-range access pulse
// master = requester side, slave = SRAM side.
// -----------------------------------------------------------------------------
interface ct_f_spsram_gen_if #(
   parameter int DATA_WIDTH = 22,
   parameter int ADDR_WIDTH = 9
);
   logic [ADDR_WIDTH-1:0] A;
   logic                  CEN;
   logic                  GWEN;
   logic [DATA_WIDTH-1:0] WEN;
   logic [DATA_WIDTH-1:0] D;
   logic [DATA_WIDTH-1:0] Q;
   logic                  BUSY;
   logic                  ADDR_ERR;

   modport master (
      output A, CEN, GWEN, WEN, D,
      input  Q, BUSY, ADDR_ERR
   );

   modport slave (
      input  A, CEN, GWEN, WEN, D,
      output Q, BUSY, ADDR_ERR
   );
endinterface

// File: rtl/ct_f_spsram_init_fsm.sv
// -----------------------------------------------------------------------------
// ct_f_spsram_init_fsm
// Zero-initialisation sweep after reset and the RAM port override mux.
//   CLK, RST      clock, synchronous active-high reset (restarts the sweep)
//   usr_*_i       address / data / per-slice write enables from the access path
//   ram_*_o       what actually reaches the fpga_ram slices
//   busy_o        high while sweeping; user accesses are ignored
// The sweep writes 0 to address 0..DEPTH-1, one word per cycle, then idles.
// -----------------------------------------------------------------------------
module ct_f_spsram_init_fsm
   import ct_f_sram_pkg::*;
#(
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 22,
   parameter int NUM_SLICE  = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] usr_addr_i,
   input  logic [DATA_WIDTH-1:0] usr_data_i,
   input  logic [NUM_SLICE-1:0]  usr_we_i,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   output logic [NUM_SLICE-1:0]  ram_we_o,
   output logic                  busy_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   sram_init_state_e      state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of block order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ram_addr_o = usr_addr_i;
      ram_data_o = usr_data_i;
      ram_we_o   = usr_we_i;
      busy_o     = 1'b0;

      unique case (state_q)
         INIT: begin
            busy_o     = 1'b1;
            ram_addr_o = cnt_q;
            ram_data_o = '0;
            ram_we_o   = '1;
            cnt_d      = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: ;
         default: state_d = INIT;
      endcase
   end

endmodule

// File: rtl/fpga_ram.sv
// -----------------------------------------------------------------------------
// fpga_ram
// Single-port synchronous block RAM, write-first: a write returns the newly
// written word on PortADataOut in the following cycle.
//   PortAClk         clock
//   PortAAddr        address
//   PortADataIn      write data
//   PortAWriteEnable write enable, active high
//   PortADataOut     registered read data (not reset)
// -----------------------------------------------------------------------------
module fpga_ram #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 10
) (
   input  logic                 PortAClk,
   input  logic [ADDRWIDTH-1:0] PortAAddr,
   input  logic [DATAWIDTH-1:0] PortADataIn,
   input  logic                 PortAWriteEnable,
   output logic [DATAWIDTH-1:0] PortADataOut
);

   logic [DATAWIDTH-1:0] mem_q [2**ADDRWIDTH];

   // NOTE: the array and its output register have no reset so they map onto
   // block RAM; the wrapper masks the unknown power-up contents instead.
   always_ff @(posedge PortAClk) begin
      if (PortAWriteEnable) begin
         mem_q[PortAAddr] <= PortADataIn;
         PortADataOut     <= PortADataIn;
      end else begin
         PortADataOut     <= mem_q[PortAAddr];
      end
   end

endmodule

// File: rtl/ct_f_spsram_gen.sv
// -----------------------------------------------------------------------------
// ct_f_spsram_gen
// DEPTH x DATA_WIDTH single-port SRAM built from NUM_SLICE fpga_ram columns.
//   CLK, RST   clock, synchronous active-high reset
//   sram_if    access bus (slave side), see ct_f_spsram_gen_if
// Features: slice-granular write mask (MSB of each WEN slice), read-data hold
// while CEN=1, zero-fill sweep after reset, optional output register
// (OUT_REG=1 adds one cycle of latency), out-of-range address detection.
// -----------------------------------------------------------------------------
module ct_f_spsram_gen
   import ct_f_sram_pkg::*;
#(
   parameter int DATA_WIDTH  = 22,
   parameter int SLICE_WIDTH = 11,
   parameter int DEPTH       = 512,
   parameter int OUT_REG     = 0,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int NUM_SLICE  = DATA_WIDTH / SLICE_WIDTH
) (
   input logic              CLK,
   input logic              RST,
   ct_f_spsram_gen_if.slave sram_if
);

   logic                  busy;
   logic                  acc, in_range, acc_ok, wr;
   logic [31:0]           a_ext;
   logic [ADDR_WIDTH-1:0] usr_addr, ram_addr;
   logic [NUM_SLICE-1:0]  usr_we, ram_we;
   logic [DATA_WIDTH-1:0] ram_data, ram_q, q_d;

   logic [ADDR_WIDTH-1:0] addr_q;   // address of the last accepted access
   logic                  vld_q;    // an in-range access has completed since reset
   logic                  oor_q;    // last accepted access was out of range
   logic                  err_q;

   // Non-MSB WEN bits are don't-care.
   logic unused_wen;
   assign unused_wen = ^sram_if.WEN;

   // Compare in 32 bits so a non-power-of-2 DEPTH is checked exactly.
   assign a_ext    = 32'(sram_if.A);
   assign in_range = a_ext < 32'(DEPTH);
   assign acc      = !RST && !busy && !sram_if.CEN;
   assign acc_ok   = acc && in_range;
   assign wr       = acc_ok && !sram_if.GWEN;

   // With no accepted access the RAM keeps re-reading the held address, so
   // its output (and therefore Q) holds the last result.
   assign usr_addr = acc_ok ? sram_if.A : addr_q;

   ct_f_spsram_init_fsm #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_SLICE  (NUM_SLICE)
   ) u_init_fsm (
      .CLK        (CLK),
      .RST        (RST),
      .usr_addr_i (usr_addr),
      .usr_data_i (sram_if.D),
      .usr_we_i   (usr_we),
      .ram_addr_o (ram_addr),
      .ram_data_o (ram_data),
      .ram_we_o   (ram_we),
      .busy_o     (busy)
   );

   for (genvar s = 0; s < NUM_SLICE; s++) begin : g_slice
      assign usr_we[s] = wr && !sram_if.WEN[slice_msb(s, SLICE_WIDTH)];

      fpga_ram #(
         .DATAWIDTH (SLICE_WIDTH),
         .ADDRWIDTH (ADDR_WIDTH)
      ) u_ram (
         .PortAClk         (CLK),
         .PortAAddr        (ram_addr),
         .PortADataIn      (ram_data[s*SLICE_WIDTH +: SLICE_WIDTH]),
         .PortAWriteEnable (ram_we[s]),
         .PortADataOut     (ram_q[s*SLICE_WIDTH +: SLICE_WIDTH])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q <= '0;
         vld_q  <= 1'b0;
         oor_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         err_q <= acc && !in_range;
         if (acc) begin
            oor_q <= !in_range;
         end
         if (acc_ok) begin
            addr_q <= sram_if.A;
            vld_q  <= 1'b1;
         end
      end
   end

   // The RAM output is unknown until the first read after reset, and an
   // out-of-range access reads as 0.
   assign q_d = (vld_q && !oor_q) ? ram_q : '0;

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_q;
      always_ff @(posedge CLK) begin
         if (RST) begin
            q_q <= '0;
         end else begin
            q_q <= q_d;
         end
      end
      assign sram_if.Q = q_q;
   end else begin : g_no_out_reg
      assign sram_if.Q = q_d;
   end

   assign sram_if.BUSY     = busy;
   assign sram_if.ADDR_ERR = err_q;

endmodule

// File: tb/tb_ct_f_spsram_gen.sv
// -----------------------------------------------------------------------------
// tb_ct_f_spsram_gen
// Directed bench for ct_f_spsram_gen with three instances sharing one stimulus
// bus: u0 (DEPTH 512, OUT_REG 0), u1 (DEPTH 512, OUT_REG 1), u2 (DEPTH 300,
// OUT_REG 0). Each instance is held in reset outside its own test phase.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_ct_f_spsram_gen;

   localparam int DW = 22;
   localparam int AW = 9;

   // Two-slice merge: upper slice of 0x2AAAAA, lower slice of 0x155555.
   localparam logic [31:0] EXP_MASKED = (32'h2AAAAA & 32'h3FF800) | (32'h155555 & 32'h0007FF);

   logic          clk = 1'b0;
   logic [2:0]    rst;
   logic [AW-1:0] a;
   logic          cen, gwen;
   logic [DW-1:0] wen, d;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ct_f_spsram_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
   ct_f_spsram_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
   ct_f_spsram_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if2 ();

   assign if0.A = a;  assign if0.CEN = cen;  assign if0.GWEN = gwen;  assign if0.WEN = wen;  assign if0.D = d;
   assign if1.A = a;  assign if1.CEN = cen;  assign if1.GWEN = gwen;  assign if1.WEN = wen;  assign if1.D = d;
   assign if2.A = a;  assign if2.CEN = cen;  assign if2.GWEN = gwen;  assign if2.WEN = wen;  assign if2.D = d;

   ct_f_spsram_gen #(.DATA_WIDTH(DW), .SLICE_WIDTH(11), .DEPTH(512), .OUT_REG(0)) u0 (
      .CLK(clk), .RST(rst[0]), .sram_if(if0.slave));
   ct_f_spsram_gen #(.DATA_WIDTH(DW), .SLICE_WIDTH(11), .DEPTH(512), .OUT_REG(1)) u1 (
      .CLK(clk), .RST(rst[1]), .sram_if(if1.slave));
   ct_f_spsram_gen #(.DATA_WIDTH(DW), .SLICE_WIDTH(11), .DEPTH(300), .OUT_REG(0)) u2 (
      .CLK(clk), .RST(rst[2]), .sram_if(if2.slave));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] q_of(input int w);
      case (w)
         0:       return 32'(if0.Q);
         1:       return 32'(if1.Q);
         default: return 32'(if2.Q);
      endcase
   endfunction

   function automatic logic busy_of(input int w);
      case (w)
         0:       return if0.BUSY;
         1:       return if1.BUSY;
         default: return if2.BUSY;
      endcase
   endfunction

   function automatic logic err_of(input int w);
      case (w)
         0:       return if0.ADDR_ERR;
         1:       return if1.ADDR_ERR;
         default: return if2.ADDR_ERR;
      endcase
   endfunction

   // Hold reset two cycles, check the reset state, then release.
   task automatic do_reset(input int w, input string tag);
      rst[w] = 1'b1;
      tick();
      tick();
      check({tag, "_rst_q"},    q_of(w),          32'h0);
      check({tag, "_rst_busy"}, 32'(busy_of(w)),  32'h1);
      check({tag, "_rst_err"},  32'(err_of(w)),   32'h0);
      rst[w] = 1'b0;
   endtask

   // Call right after releasing reset: counts BUSY cycles (bounded) and
   // requires Q to stay 0 for the whole sweep.
   task automatic run_sweep(input int w, input string tag, input int exp_len);
      int   n;
      logic q_bad;
      n     = 0;
      q_bad = 1'b0;
      while (busy_of(w) && n < 2000) begin
         if (q_of(w) !== 32'h0) q_bad = 1'b1;
         tick();
         n++;
      end
      check({tag, "_busy_len"}, 32'(n), 32'(exp_len));
      check({tag, "_sweep_q0"}, 32'(q_bad), 32'h0);
   endtask

   task automatic acc_wr(input int addr, input logic [31:0] data, input logic [31:0] w);
      a    = AW'(addr);
      d    = DW'(data);
      wen  = DW'(w);
      cen  = 1'b0;
      gwen = 1'b0;
      tick();
      cen  = 1'b1;
      gwen = 1'b1;
   endtask

   task automatic acc_rd(input int addr);
      a    = AW'(addr);
      cen  = 1'b0;
      gwen = 1'b1;
      tick();
      cen  = 1'b1;
   endtask

   initial begin
      rst  = 3'b111;
      a    = '0;
      cen  = 1'b1;
      gwen = 1'b1;
      wen  = '1;
      d    = '0;

      // ---------------- u0: DEPTH 512, OUT_REG 0 ----------------
      do_reset(0, "u0");
      run_sweep(0, "u0", 512);
      for (int i = 0; i < 512; i++) begin
         acc_rd(i);
         check($sformatf("u0_zero_%0d", i), q_of(0), 32'h0);
      end

      acc_wr(32'h1F0, 32'h2AAAAA, 32'h0);
      check("u0_wr_full_q", q_of(0), 32'h2AAAAA);
      acc_wr(32'h1F0, 32'h155555, 32'h2003FF);
      check("u0_wr_mask_q", q_of(0), EXP_MASKED);
      acc_rd(32'h1EF);
      check("u0_rd_neigh", q_of(0), 32'h0);
      acc_rd(32'h1F0);
      check("u0_rd_mask", q_of(0), EXP_MASKED);

      // Read hold: CEN=1 with a different address and write attempts.
      acc_wr(7, 32'h77, 32'h0);
      acc_rd(7);
      check("u0_rd7", q_of(0), 32'h77);
      a    = AW'(8);
      d    = '1;
      wen  = '0;
      gwen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("u0_hold_%0d", i), q_of(0), 32'h77);
      end
      gwen = 1'b1;
      check("u0_held_addr", 32'(u0.addr_q), 32'd7);
      acc_rd(8);
      check("u0_rd8_untouched", q_of(0), 32'h0);

      // Reset coinciding with a read: the result must never appear.
      a      = AW'(7);
      cen    = 1'b0;
      gwen   = 1'b1;
      rst[0] = 1'b1;
      tick();
      check("u0_rstrd_q", q_of(0), 32'h0);
      cen = 1'b1;
      tick();
      check("u0_rstrd_q2",   q_of(0),          32'h0);
      check("u0_rstrd_busy", 32'(busy_of(0)),  32'h1);
      rst[0] = 1'b0;
      run_sweep(0, "u0_rstrd", 512);

      // Reset at sweep count 100 restarts a full sweep.
      acc_wr(7, 32'h77, 32'h0);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      repeat (100) tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      run_sweep(0, "u0_rst100", 512);
      acc_rd(7);
      check("u0_cleared7", q_of(0), 32'h0);
      acc_rd(32'h1F0);
      check("u0_cleared1f0", q_of(0), 32'h0);
      rst[0] = 1'b1;

      // ---------------- u1: DEPTH 512, OUT_REG 1 ----------------
      do_reset(1, "u1");
      run_sweep(1, "u1", 512);
      for (int i = 3; i <= 5; i++) acc_wr(i, 32'(i), 32'h0);
      acc_rd(10);
      tick();
      tick();
      check("u1_pre_q", q_of(1), 32'h0);

      a    = AW'(3);
      cen  = 1'b0;
      gwen = 1'b1;
      tick();
      check("u1_lat_c1", q_of(1), 32'h0);
      a = AW'(4);
      tick();
      check("u1_q3", q_of(1), 32'd3);
      a = AW'(5);
      tick();
      check("u1_q4", q_of(1), 32'd4);
      cen = 1'b1;
      tick();
      check("u1_q5", q_of(1), 32'd5);
      tick();
      check("u1_q5_hold", q_of(1), 32'd5);

      // Reset while the read of address 4 is in the output stage.
      a   = AW'(4);
      cen = 1'b0;
      tick();
      cen    = 1'b1;
      rst[1] = 1'b1;
      tick();
      check("u1_rstrd_q", q_of(1), 32'h0);
      tick();
      check("u1_rstrd_q2", q_of(1), 32'h0);
      rst[1] = 1'b0;
      run_sweep(1, "u1_rstrd", 512);
      rst[1] = 1'b1;

      // ---------------- u2: DEPTH 300, OUT_REG 0 ----------------
      do_reset(2, "u2");
      run_sweep(2, "u2", 300);
      acc_wr(299, 32'h0ABCDE, 32'h0);
      check("u2_wr299_err", 32'(err_of(2)), 32'h0);
      acc_wr(300, 32'h3FFFFF, 32'h0);
      check("u2_wr300_err", 32'(err_of(2)), 32'h1);
      tick();
      check("u2_err_pulse", 32'(err_of(2)), 32'h0);
      acc_rd(299);
      check("u2_rd299",     q_of(2),         32'h0ABCDE);
      check("u2_rd299_err", 32'(err_of(2)),  32'h0);
      acc_rd(300);
      check("u2_rd300",     q_of(2),         32'h0);
      check("u2_rd300_err", 32'(err_of(2)),  32'h1);
      check("u2_held_addr", 32'(u2.addr_q),  32'd299);
      tick();
      check("u2_err_clr",   32'(err_of(2)),  32'h0);
      check("u2_oor_hold",  q_of(2),         32'h0);
      acc_rd(511);
      check("u2_rd511",     q_of(2),         32'h0);
      check("u2_rd511_err", 32'(err_of(2)),  32'h1);
      acc_rd(299);
      check("u2_rd299_again", q_of(2),       32'h0ABCDE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
